// File: rtl/div_ctrl_if.sv
// Request, divider and write-back signal bundle for div_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline/divider side.
interface div_ctrl_if;
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_dividend_i;
  logic [31:0] req_divisor_i;
  logic [4:0]  req_waddr_i;
  logic        req_ready_o;
  logic        flush_i;
  logic        stall_o;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [4:0]  div_waddr_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic        wb_valid_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_ready_i;

  modport slave (
    input  req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_waddr_i, flush_i,
           div_result_i, div_ready_i, wb_ready_i,
    output req_ready_o, stall_o, div_start_o, div_op_o, div_dividend_o, div_divisor_o,
           div_waddr_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );

  modport master (
    output req_valid_i, req_op_i, req_dividend_i, req_divisor_i, req_waddr_i, flush_i,
           div_result_i, div_ready_i, wb_ready_i,
    input  req_ready_o, stall_o, div_start_o, div_op_o, div_dividend_o, div_divisor_o,
           div_waddr_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Issue/write-back controller in front of the iterative divider (IDLE -> BUSY -> WB).
// Define DIV_CTRL_CACHE_EN to reuse the last completed result for an identical request.
module div_ctrl (
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]  state;
  logic        start_r;
  logic [2:0]  op_r;
  logic [31:0] dividend_r;
  logic [31:0] divisor_r;
  logic [4:0]  waddr_r;
  logic        wb_valid_r;
  logic [4:0]  wb_waddr_r;
  logic [31:0] wb_wdata_r;
  logic        accept;
  logic        cache_hit;
  logic [31:0] cache_result;

  assign accept = (state == IDLE) & bus.req_valid_i & ~bus.flush_i;

`ifdef DIV_CTRL_CACHE_EN
  logic [2:0]  c_op;
  logic [31:0] c_dividend;
  logic [31:0] c_divisor;
  logic [31:0] c_result;
  logic        c_valid;

  // Only a normal completion refreshes the entry; flushed operations never reach it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_valid    <= 1'b0;
      c_op       <= '0;
      c_dividend <= '0;
      c_divisor  <= '0;
      c_result   <= '0;
    end else if ((state == BUSY) && !bus.flush_i && bus.div_ready_i) begin
      c_valid    <= 1'b1;
      c_op       <= op_r;
      c_dividend <= dividend_r;
      c_divisor  <= divisor_r;
      c_result   <= bus.div_result_i;
    end
  end

  assign cache_hit    = c_valid & (c_op == bus.req_op_i) &
                        (c_dividend == bus.req_dividend_i) & (c_divisor == bus.req_divisor_i);
  assign cache_result = c_result;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_r    <= 1'b0;
      op_r       <= '0;
      dividend_r <= '0;
      divisor_r  <= '0;
      waddr_r    <= '0;
      wb_valid_r <= 1'b0;
      wb_waddr_r <= '0;
      wb_wdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r       <= bus.req_op_i;
            dividend_r <= bus.req_dividend_i;
            divisor_r  <= bus.req_divisor_i;
            waddr_r    <= bus.req_waddr_i;
            if (cache_hit) begin
              wb_valid_r <= 1'b1;
              wb_waddr_r <= bus.req_waddr_i;
              wb_wdata_r <= cache_result;
              state      <= WB;
            end else begin
              start_r <= 1'b1;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // Flush wins over a coincident result pulse: the instruction is not yet committed.
          if (bus.flush_i) begin
            start_r <= 1'b0;
            state   <= IDLE;
          end else if (bus.div_ready_i) begin
            wb_wdata_r <= bus.div_result_i;
            wb_waddr_r <= waddr_r;
            wb_valid_r <= 1'b1;
            start_r    <= 1'b0;
            state      <= WB;
          end
        end
        WB: begin
          if (bus.wb_ready_i) begin
            wb_valid_r <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          start_r    <= 1'b0;
          wb_valid_r <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o    = (state == IDLE);
  assign bus.stall_o        = (state != IDLE) | (bus.req_valid_i & ~bus.flush_i);
  // Gated so the divider, already back in idle during its ready cycle, does not restart.
  assign bus.div_start_o    = start_r & ~bus.div_ready_i;
  assign bus.div_op_o       = op_r;
  assign bus.div_dividend_o = dividend_r;
  assign bus.div_divisor_o  = divisor_r;
  assign bus.div_waddr_o    = waddr_r;
  assign bus.wb_valid_o     = wb_valid_r;
  assign bus.wb_waddr_o     = wb_waddr_r;
  assign bus.wb_wdata_o     = wb_wdata_r;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divider (latency 33, or 2 for a zero divisor).
module tb_div_ctrl;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;
`ifdef DIV_CTRL_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 35;
`endif

  logic clk = 1'b0;
  logic rst;
  div_ctrl_if bus ();

  div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] div_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    logic [31:0] r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  if (b == 0) r = '1; else if (ovf) r = 32'h8000_0000; else r = $signed(a) / $signed(b);
      OP_DIVU: if (b == 0) r = '1; else r = a / b;
      OP_REM:  if (b == 0) r = a;  else if (ovf) r = '0; else r = $signed(a) % $signed(b);
      default: if (b == 0) r = a;  else r = a % b;
    endcase
    return r;
  endfunction

  // Divider model: counts start-high cycles, pulses ready for one cycle after L of them.
  logic        m_ready;
  logic [31:0] m_result;
  int unsigned m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ready <= 1'b0; m_cnt <= 0; m_result <= '0;
    end else if (m_ready) begin
      m_ready <= 1'b0; m_cnt <= 0;
    end else if (bus.div_start_o) begin
      if (m_cnt + 1 == ((bus.div_divisor_o == 0) ? 2 : 33)) begin
        m_ready  <= 1'b1;
        m_result <= div_ref(bus.div_op_o, bus.div_dividend_o, bus.div_divisor_o);
      end
      m_cnt <= m_cnt + 1;
    end else begin
      m_cnt <= 0;
    end
  end
  assign bus.div_ready_i  = m_ready;
  assign bus.div_result_i = m_ready ? m_result : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE; returns #1 after the accept edge (cycle 1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
    chk("req_ready_idle", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1; bus.req_op_i = op;
    bus.req_dividend_i = a; bus.req_divisor_i = b; bus.req_waddr_i = wa;
    #1 chk("stall_on_req", bus.stall_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(input int exp_lat);
    int cyc = 1;
    int starts = 0;
    bit seen = 0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if (bus.wb_valid_o) seen = 1;
      else begin
        chk("stall_busy", bus.stall_o, 1);
        if (bus.div_ready_i) chk("start_gated", bus.div_start_o, 0);
        if (bus.div_start_o) starts++;
        cyc++;
      end
    end
    if (!seen) chk("wb_timeout", 0, 1);
    else begin
      chk("wb_latency", cyc, exp_lat);
      chk("start_cycles", starts, (exp_lat >= 2) ? exp_lat - 2 : 0);
      chk("start_low_wb", bus.div_start_o, 0);
      chk("stall_wb", bus.stall_o, 1);
    end
  endtask

  // Called at the negedge of a wb_valid cycle; returns at the negedge of the next IDLE cycle.
  task automatic finish_wb(input logic [31:0] exp_data, input logic [4:0] exp_wa);
    chk("wb_wdata", bus.wb_wdata_o, exp_data);
    chk("wb_waddr", bus.wb_waddr_o, exp_wa);
    chk("req_ready_wb", bus.req_ready_o, 0);
    bus.wb_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready_i = 1'b0;
    @(negedge clk);
    chk("wb_valid_drop", bus.wb_valid_o, 0);
    chk("req_ready_back", bus.req_ready_o, 1);
    chk("stall_idle", bus.stall_o, 0);
    chk("start_idle", bus.div_start_o, 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 35};
    vecs[1] = '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 35};
    vecs[2] = '{OP_DIVU, 32'h0000_0064, 32'h0000_0000, 5'd7,  32'hFFFF_FFFF, 4};
    vecs[3] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 35};
    vecs[4] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 35};
    vecs[5] = '{OP_REMU, 32'h0000_0064, 32'h0000_0000, 5'd10, 32'h0000_0064, 4};
    vecs[6] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd31, 32'h0FFF_FFFF, 35};
    vecs[7] = '{OP_REMU, 32'h0000_0064, 32'h0000_0007, 5'd1,  32'h0000_0002, 35};

    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_dividend_i = '0;
    bus.req_divisor_i = '0; bus.req_waddr_i = '0; bus.flush_i = 1'b0; bus.wb_ready_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_wb_valid", bus.wb_valid_o, 0);
    chk("rst_wb_wdata", bus.wb_wdata_o, 0);
    chk("rst_wb_waddr", bus.wb_waddr_o, 0);
    chk("rst_start", bus.div_start_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_div_op", bus.div_op_o, 0);
    chk("rst_div_dividend", bus.div_dividend_o, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = OP_DIVU; bus.req_dividend_i = 32'd5;
    bus.req_divisor_i = 32'd1; bus.flush_i = 1'b1;
    #1 chk("idle_flush_stall", bus.stall_o, 0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    chk("idle_flush_start", bus.div_start_o, 0);
    chk("idle_flush_ready", bus.req_ready_o, 1);
    chk("idle_flush_stall2", bus.stall_o, 0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa);
      wait_wb(vecs[i].lat);
      finish_wb(vecs[i].exp, vecs[i].wa);
    end

    // Flush in BUSY at cycle 10, then an immediate new request.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_start_c10", bus.div_start_o, 1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_start_low", bus.div_start_o, 0);
    chk("flush_no_wb", bus.wb_valid_o, 0);
    chk("flush_ready", bus.req_ready_o, 1);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd4);
    wait_wb(35);
    finish_wb(32'h0000_000E, 5'd4);

    // Identical repeat: served from the cache when it is built in.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd13);
    wait_wb(HIT_LAT);
    finish_wb(32'h0000_000E, 5'd13);

    // Reset mid-operation drops start at once and clears any cached entry.
    issue(OP_DIVU, 32'd200, 32'd7, 5'd14);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_start", bus.div_start_o, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_start", bus.div_start_o, 0);
    chk("mid_rst_ready", bus.req_ready_o, 1);
    chk("mid_rst_stall", bus.stall_o, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7, 5'd15);
    wait_wb(35);
    finish_wb(32'h0000_000E, 5'd15);

    // Back-pressure in WB with a flush pulse that must not drop the write.
    issue(OP_DIV, 32'h0000_0064, 32'h0000_0000, 5'd12);
    wait_wb(4);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", bus.wb_valid_o, 1);
      chk("hold_wdata", bus.wb_wdata_o, 32'hFFFF_FFFF);
      chk("hold_waddr", bus.wb_waddr_o, 5'd12);
      chk("hold_req_ready", bus.req_ready_o, 0);
      chk("hold_stall", bus.stall_o, 1);
      if (k == 2) bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      @(negedge clk);
    end
    finish_wb(32'hFFFF_FFFF, 5'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
